vscale_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the core's decode/execute (DX) stage.
- Generates the fetch PC and issues pipelined instruction-memory transfers with wait-state support.
- Buffers returned instructions in a small FIFO and presents {inst, pc} to DX with a valid/ready handshake.
- Handles redirects (branch, jump, trap) by flushing buffered and in-flight fetches.

---
 rtl/vscale_fetch_unit_if.sv | 24 ++
 rtl/vscale_fetch_unit.sv | 116 +++++++++++
 tb/tb_vscale_fetch_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vscale_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory bus, DX-facing instruction handshake and redirect request.
// The master view belongs to the fetch unit; the slave view belongs to memory/DX.
interface vscale_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_wait;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_wait, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_wait, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/vscale_fetch_unit.sv
// Instruction fetch: pipelined AHB-lite style imem transfers feeding a small FIFO toward DX.
// Redirects flush the FIFO and mark any in-flight transfer as dead so its data is dropped.
module vscale_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0200,
  parameter int          FBUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input logic                 hclk,
  input logic                 hresetn,
  vscale_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(FBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              started_p0;
  logic              stall_p0;
  logic [31:0]       pc_p0;
  logic              pend_vld_p0;
  logic [31:0]       pend_pc_p0;
  logic              vld_p1;
  logic              live_p1;
  logic [31:0]       pc_p1;
  logic [31:0]       fbuf_inst [FBUF_DEPTH];
  logic [31:0]       fbuf_pc   [FBUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [31:0]       redir_tgt;
  logic              aph_go;
  logic              dph_done;
  logic              push;
  logic              pop;
  logic              issue_ok;
  logic [CNT_W:0]    occ;
  logic [CNT_W:0]    room;

  assign redir_tgt = {bus.redirect_pc[31:2], 2'b00};
  assign aph_go    = bus.imem_req & ~bus.imem_wait;
  assign dph_done  = vld_p1 & ~bus.imem_wait;
  assign push      = dph_done & live_p1 & ~bus.redirect_valid;
  assign pop       = bus.inst_valid & bus.inst_ready;

  // A live data phase already owns a slot; a same-cycle pop frees one.
  assign occ      = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1 & live_p1};
  assign room     = (CNT_W+1)'(FBUF_DEPTH) + {{CNT_W{1'b0}}, pop};
  assign issue_ok = occ < room;

  // A stalled address phase must hold its request even if the issue rule changes.
  assign bus.imem_req   = started_p0 & (stall_p0 | issue_ok);
  assign bus.imem_addr  = pc_p0;
  assign bus.inst_valid = (count != '0);
  assign bus.inst       = bus.inst_valid ? fbuf_inst[rd_ptr] : NOP_INST;
  assign bus.inst_pc    = bus.inst_valid ? fbuf_pc[rd_ptr]   : pc_p0;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      started_p0  <= 1'b0;
      stall_p0    <= 1'b0;
      pc_p0       <= RESET_PC;
      pend_vld_p0 <= 1'b0;
      vld_p1      <= 1'b0;
      live_p1     <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      started_p0 <= 1'b1;
      stall_p0   <= bus.imem_req & bus.imem_wait;

      // p0: address phase / fetch pc
      if (bus.redirect_valid) begin
        if (bus.imem_req & bus.imem_wait) begin
          pend_vld_p0 <= 1'b1;
        end else begin
          pend_vld_p0 <= 1'b0;
          pc_p0       <= redir_tgt;
        end
      end else if (aph_go) begin
        pc_p0       <= pend_vld_p0 ? pend_pc_p0 : pc_p0 + 32'd4;
        pend_vld_p0 <= 1'b0;
      end

      // p1: data phase; live_p1 clear means the returned word is discarded
      if (aph_go) begin
        vld_p1  <= 1'b1;
        live_p1 <= ~bus.redirect_valid & ~pend_vld_p0;
      end else begin
        if (dph_done) vld_p1 <= 1'b0;
        if (bus.redirect_valid) live_p1 <= 1'b0;
      end

      // fetch buffer occupancy
      if (bus.redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (bus.redirect_valid & bus.imem_req & bus.imem_wait) pend_pc_p0 <= redir_tgt;
    if (aph_go) pc_p1 <= pc_p0;
    if (push) begin
      fbuf_inst[wr_ptr] <= bus.imem_rdata;
      fbuf_pc[wr_ptr]   <= pc_p1;
    end
  end

endmodule

// File: tb/tb_vscale_fetch_unit.sv
// Directed bench for vscale_fetch_unit: memory returns addr^32'hA5A5_0000 for each accepted address.
module tb_vscale_fetch_unit;

  logic        hclk;
  logic        hresetn;
  logic [31:0] dph_addr;
  int          total;
  int          bad;

  vscale_fetch_unit_if bus();

  vscale_fetch_unit #(
    .RESET_PC  (32'h0000_0200),
    .FBUF_DEPTH(2),
    .NOP_INST  (32'h0000_0013)
  ) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .bus    (bus)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  // Simple zero/extended-wait memory: remembers the accepted address for its data phase.
  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) dph_addr <= 32'h0;
    else if (bus.imem_req && !bus.imem_wait) dph_addr <= bus.imem_addr;
  end
  assign bus.imem_rdata = dph_addr ^ 32'hA5A5_0000;

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vld"},  {31'h0, bus.inst_valid}, 32'h0);
    chk({tag, "_inst"}, bus.inst,                 32'h0000_0013);
    chk({tag, "_pc"},   bus.inst_pc,              32'h0000_0200);
    chk({tag, "_req"},  {31'h0, bus.imem_req},    32'h0);
    chk({tag, "_addr"}, bus.imem_addr,            32'h0000_0200);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_vld"},  {31'h0, bus.inst_valid}, 32'h1);
    chk({tag, "_pc"},   bus.inst_pc,              pc);
    chk({tag, "_inst"}, bus.inst,                 pc ^ 32'hA5A5_0000);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    hresetn = 1'b0;
    bus.imem_wait      = 1'b0;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    repeat (3) tick;
    chk_reset("rst");

    hresetn = 1'b1;
    tick;
    chk("c0_req",  {31'h0, bus.imem_req},   32'h1);
    chk("c0_addr", bus.imem_addr,           32'h0000_0200);
    chk("c0_vld",  {31'h0, bus.inst_valid}, 32'h0);
    tick;
    chk("c1_vld",  {31'h0, bus.inst_valid}, 32'h0);
    chk("c1_addr", bus.imem_addr,           32'h0000_0204);
    for (int k = 2; k <= 5; k++) begin
      tick;
      chk_head("stream", 32'h0000_0200 + 32'(4 * (k - 2)));
      chk("stream_addr", bus.imem_addr, 32'h0000_0200 + 32'(4 * k));
    end

    // DX stalls: buffer fills to two entries and requests stop
    bus.inst_ready = 1'b0;
    repeat (4) tick;
    chk_head("hold", 32'h0000_020C);
    chk("hold_req",  {31'h0, bus.imem_req}, 32'h0);
    chk("hold_addr", bus.imem_addr,         32'h0000_0214);
    bus.inst_ready = 1'b1;
    tick; chk_head("rel0", 32'h0000_0210);
    tick; chk_head("rel1", 32'h0000_0214);
    tick; chk_head("rel2", 32'h0000_0218);

    // three wait states with 0x21C in its data phase and 0x220 in address phase
    bus.imem_wait = 1'b1;
    tick;
    chk("w0_addr", bus.imem_addr,           32'h0000_0220);
    chk("w0_req",  {31'h0, bus.imem_req},   32'h1);
    chk("w0_vld",  {31'h0, bus.inst_valid}, 32'h0);
    tick;
    chk("w1_addr", bus.imem_addr,           32'h0000_0220);
    chk("w1_vld",  {31'h0, bus.inst_valid}, 32'h0);
    tick;
    chk("w2_vld",  {31'h0, bus.inst_valid}, 32'h0);
    bus.imem_wait = 1'b0;
    tick;
    chk_head("wdone", 32'h0000_021C);
    chk("wdone_addr", bus.imem_addr, 32'h0000_0224);

    // redirect with 0x220 in its data phase; target low bits are dropped
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_1003;
    tick;
    bus.redirect_valid = 1'b0;
    chk("r0_vld",  {31'h0, bus.inst_valid}, 32'h0);
    chk("r0_addr", bus.imem_addr,           32'h0000_1000);
    tick;
    chk("r1_vld",  {31'h0, bus.inst_valid}, 32'h0);
    chk("r1_addr", bus.imem_addr,           32'h0000_1004);
    tick;
    chk_head("r2", 32'h0000_1000);

    // redirect while the 0x1008 address phase is stalled
    bus.imem_wait = 1'b1;
    tick;
    chk("s0_addr", bus.imem_addr,           32'h0000_1008);
    chk("s0_req",  {31'h0, bus.imem_req},   32'h1);
    chk("s0_vld",  {31'h0, bus.inst_valid}, 32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_2000;
    tick;
    bus.redirect_valid = 1'b0;
    chk("s1_addr", bus.imem_addr,           32'h0000_1008);
    chk("s1_req",  {31'h0, bus.imem_req},   32'h1);
    chk("s1_vld",  {31'h0, bus.inst_valid}, 32'h0);
    tick;
    chk("s2_addr", bus.imem_addr, 32'h0000_1008);
    bus.imem_wait = 1'b0;
    tick;
    chk("s3_addr", bus.imem_addr,           32'h0000_2000);
    chk("s3_vld",  {31'h0, bus.inst_valid}, 32'h0);
    tick;
    chk("s4_addr", bus.imem_addr,           32'h0000_2004);
    chk("s4_vld",  {31'h0, bus.inst_valid}, 32'h0);
    tick;
    chk_head("s5", 32'h0000_2000);

    // address wrap at the top of memory
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    tick;
    bus.redirect_valid = 1'b0;
    chk("x0_addr", bus.imem_addr, 32'hFFFF_FFF8);
    tick;
    chk("x1_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick;
    chk("x2_addr", bus.imem_addr, 32'h0000_0000);
    chk_head("x2", 32'hFFFF_FFF8);
    tick;
    chk_head("x3", 32'hFFFF_FFFC);
    chk("x3_addr", bus.imem_addr, 32'h0000_0004);
    tick;
    chk_head("x4", 32'h0000_0000);

    // asynchronous reset in the middle of a cycle with a data phase in flight
    #2 hresetn = 1'b0;
    #1 chk_reset("arst");
    tick;
    tick;
    hresetn = 1'b1;
    tick;
    chk("ar0_req",  {31'h0, bus.imem_req},   32'h1);
    chk("ar0_addr", bus.imem_addr,           32'h0000_0200);
    chk("ar0_vld",  {31'h0, bus.inst_valid}, 32'h0);
    tick;
    tick;
    chk_head("ar2", 32'h0000_0200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
